// File: rtl/fade_apply.sv
// rtl/fade_apply.sv - applies a complex fading coefficient to a sample stream
//
// Purpose: each accepted complex Q1.15 sample is multiplied by the currently
// applied Q1.15 coefficient A. The multiplier is a three-stage pipeline and
// its output is rounded half up and saturated. A new coefficient arrives as a
// single-cycle coef_dv pulse and can arrive at any time.
//
// Build option: FADE_INTERP_EN
//   defined   - A ramps linearly from the coefficient in use to the new one
//               over 2^INTERP_LOG2 accepted samples.
//   undefined - zero-order hold; A jumps to the new coefficient.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   coef_dv               new coefficient strobe (no backpressure)
//   coef_real, coef_imag  signed Q1.15 coefficient
//   s_valid / s_ready     input sample handshake
//   s_real, s_imag        signed Q1.15 input sample
//   m_valid / m_ready     output sample handshake
//   m_real, m_imag        signed Q1.15 faded sample
module fade_apply #(
    parameter int INTERP_LOG2 = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        coef_dv,
    input  logic [15:0] coef_real,
    input  logic [15:0] coef_imag,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_real,
    input  logic [15:0] s_imag,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [15:0] m_real,
    output logic [15:0] m_imag
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic en;
    logic accept;

    // Coefficient applied to a sample accepted this cycle.
    logic signed [15:0] a_re, a_im;

    assign en     = !m_valid || m_ready;
    assign accept = s_valid && s_ready;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == IDLE && coef_dv) begin
            state_nxt = RUN;
        end
    end

    always_comb begin
        s_ready = (state == RUN) && en;
    end

    // ------------------------------------------------------------------
    // Coefficient tracking
    // ------------------------------------------------------------------
`ifdef FADE_INTERP_EN
    localparam int NW = INTERP_LOG2 + 1;
    localparam int PW = 17 + NW + 1;
    localparam logic [NW-1:0] N_FULL = NW'(1 << INTERP_LOG2);

    logic signed [15:0] b_re, b_im, t_re, t_im;
    logic signed [16:0] d_re, d_im;
    logic [NW-1:0]      n;

    // B + ((D*n) >>> INTERP_LOG2); at n = 2^INTERP_LOG2 this is exactly T.
    // The result always lies between B and T, so it fits in 16 bits.
    function automatic logic signed [15:0] ramp(
        input logic signed [15:0] b,
        input logic signed [16:0] d,
        input logic [NW-1:0]      cnt
    );
        logic signed [PW-1:0] prod;
        prod = PW'(d) * PW'($signed({1'b0, cnt}));
        return 16'(PW'(b) + (prod >>> INTERP_LOG2));
    endfunction

    assign a_re = ramp(b_re, d_re, n);
    assign a_im = ramp(b_im, d_im, n);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            b_re <= '0;
            b_im <= '0;
            t_re <= '0;
            t_im <= '0;
            d_re <= '0;
            d_im <= '0;
            n    <= '0;
        end else if (coef_dv) begin
            if (state == IDLE) begin
                // First coefficient: no ramp, apply it directly.
                b_re <= $signed(coef_real);
                b_im <= $signed(coef_imag);
                t_re <= $signed(coef_real);
                t_im <= $signed(coef_imag);
                d_re <= '0;
                d_im <= '0;
                n    <= N_FULL;
            end else begin
                // Ramp restarts from whatever A is right now, so a
                // coefficient arriving mid-ramp causes no step.
                b_re <= a_re;
                b_im <= a_im;
                t_re <= $signed(coef_real);
                t_im <= $signed(coef_imag);
                d_re <= 17'($signed(coef_real)) - 17'(a_re);
                d_im <= 17'($signed(coef_imag)) - 17'(a_im);
                n    <= '0;
            end
        end else if (accept && n != N_FULL) begin
            n <= n + 1'b1;
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_re <= '0;
            a_im <= '0;
        end else if (coef_dv) begin
            a_re <= $signed(coef_real);
            a_im <= $signed(coef_imag);
        end
    end
`endif

    // ------------------------------------------------------------------
    // Complex multiply pipeline
    // ------------------------------------------------------------------
    logic               v1, v2;
    logic signed [15:0] x_re, x_im, c_re, c_im;
    logic signed [31:0] p_rr, p_ii, p_ri, p_ir;

    // Round half up, drop 15 fraction bits, clamp to 16-bit signed.
    function automatic logic [15:0] round_sat(input logic signed [32:0] s);
        logic signed [32:0] r;
        r = (s + 33'sd16384) >>> 15;
        if (r > 33'sd32767) begin
            return 16'h7FFF;
        end else if (r < -33'sd32768) begin
            return 16'h8000;
        end else begin
            return r[15:0];
        end
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1      <= 1'b0;
            x_re    <= '0;
            x_im    <= '0;
            c_re    <= '0;
            c_im    <= '0;
            v2      <= 1'b0;
            p_rr    <= '0;
            p_ii    <= '0;
            p_ri    <= '0;
            p_ir    <= '0;
            m_valid <= 1'b0;
            m_real  <= '0;
            m_imag  <= '0;
        end else if (en) begin
            // S1: capture sample with the coefficient in force before any
            // same-cycle coef_dv update.
            v1      <= accept;
            x_re    <= $signed(s_real);
            x_im    <= $signed(s_imag);
            c_re    <= a_re;
            c_im    <= a_im;
            // S2: partial products
            v2      <= v1;
            p_rr    <= 32'(x_re) * 32'(c_re);
            p_ii    <= 32'(x_im) * 32'(c_im);
            p_ri    <= 32'(x_re) * 32'(c_im);
            p_ir    <= 32'(x_im) * 32'(c_re);
            // S3: combine, round, saturate
            m_valid <= v2;
            m_real  <= round_sat(33'(p_rr) - 33'(p_ii));
            m_imag  <= round_sat(33'(p_ri) + 33'(p_ir));
        end
    end

endmodule

// File: doc/fade_apply.md
# fade_apply

Downstream consumer of the fader coefficient generator. Takes each complex fading coefficient (`dv_out`/`Zc_real`/`Zc_imag` pulse) and applies it to a continuous complex baseband sample stream through a pipelined, rounded and saturating complex multiplier. An optional mode ramps linearly from the previous coefficient to the new one. The block sits between the signal source and the channel-output path of the fading channel model.

## Interface
- `INTERP_LOG2`, default 4. Interpolation ramp length is 2^INTERP_LOG2 accepted samples. Legal range is 0..10. It has no effect without `FADE_INTERP_EN`.
- `clk` input, 1 bit. Single clock.
- `reset` input, 1 bit. Asynchronous, active-high.
- `coef_dv` input, 1 bit. A new coefficient is valid this cycle. There is no backpressure on this input.
- `coef_real`, `coef_imag` input, 16 bits each. Signed Q1.15 coefficient.
- `s_valid` input, 1 bit. Input sample valid.
- `s_ready` output, 1 bit. Block can accept an input sample.
- `s_real`, `s_imag` input, 16 bits each. Signed Q1.15 input sample.
- `m_valid` output, 1 bit. Output sample valid.
- `m_ready` input, 1 bit. Downstream accepts the output sample.
- `m_real`, `m_imag` output, 16 bits each. Signed Q1.15 faded sample.

## Operation
- **States.**
  - IDLE: the block has received no coefficient yet. `s_ready`=0.
  - RUN: the block entered RUN on the first `coef_dv`. It stays in RUN until reset.
- **IDLE→RUN transition.** The first `coef_dv` loads the applied coefficient A, the base B and the target T, all with the incoming coefficient. It also sets the ramp counter n to 2^INTERP_LOG2, so no ramp runs.
- **Coefficient update in RUN.** On `coef_dv`:
  - B ← A_current.
  - T ← the incoming coefficient.
  - D ← T − B, computed at 17-bit signed width.
  - n ← 0.
- **Applied coefficient (with `FADE_INTERP_EN`).** A = B + ((D·n) >>> INTERP_LOG2), using an arithmetic shift.
  - n increments on each accepted sample and saturates at 2^INTERP_LOG2.
  - When n = 2^INTERP_LOG2, A = T exactly.
- **Sample/coefficient alignment.** An accepted sample uses the A value derived from the register state before any update in that same cycle.
  - Simultaneous `coef_dv` and acceptance: the sample uses the old A. The new ramp starts with the next accepted sample at n=0, which gives A=B.
- **Multiply.**
  - Products are 32-bit signed.
  - re = ac − bd and im = ad + bc are 33-bit.
  - Add 2^14 (round half up), then arithmetic shift right by 15.
  - Saturate to the range [−32768, 32767].
- **Handshake.**
  - Advance enable: en = !m_valid | m_ready.
  - `s_ready` = (state==RUN) & en.
  - A sample is accepted when `s_valid` & `s_ready`.
  - An output transfers when `m_valid` & `m_ready`.
- **Coefficient updates during a stall.** `coef_dv` updates B, T, D and n even while the pipeline is stalled. Samples already in the pipeline keep their captured coefficient.

## Timing
- **Pipeline stages.** The pipeline has 3 stages, all gated by en:
  - S1: register the sample and A.
  - S2: compute the four products.
  - S3: sum, round, saturate, and drive `m_*`.
- **Latency.** 3 cycles from acceptance to `m_valid`. Throughput is 1 sample per cycle while `m_ready`=1.
- **Stall behaviour.** When `m_ready`=0 and `m_valid`=1:
  - All stages hold.
  - `m_*` stays stable.
  - No sample is dropped or duplicated.
- **Pipeline bubbles.** A bubble is a stage with valid=0. Bubbles advance and collapse normally.
- **Reset values.** All outputs are 0: `s_ready`, `m_valid`, `m_real`, `m_imag`. State = IDLE. A, B, T, D and n are 0. All pipeline valid bits are 0.
- **Reset mid-stream.** Asserting `reset` mid-stream flushes all in-flight samples. After release, the block waits for a new `coef_dv`.
- **Update rate.** Back-to-back `coef_dv` in consecutive cycles is legal. The last one wins, and each restarts the ramp from the current A.

## Configuration
- **`FADE_INTERP_EN` defined:** linear interpolation as described in Operation, using the counter and the D·n multiplier.
- **`FADE_INTERP_EN` undefined:** zero-order hold.
  - A ← the coefficient on every `coef_dv`. The same alignment rule applies: the new A is used from the next accepted sample.
  - B, D, n and the interpolation logic are not built. `INTERP_LOG2` is ignored.

## Test plan
- **Scaling (hold mode).** Stimulus: coef (0x4000, 0x0000), then sample (0x2000, 0xE000). Required: after 3 cycles, `m` = (0x1000, 0xF000).
- **Rotation by j.** Stimulus: coef (0x0000, 0x4000), then sample (0x4000, 0x0000). Required: `m` = (0x0000, 0x2000).
- **Saturation.** Stimulus: coef (0x8000, 0x0000), sample (0x8000, 0x0000). Required: `m` = (0x7FFF, 0x0000).
- **Backpressure.** Stimulus: continuous stream with an incrementing counter pattern; hold `m_ready`=0 for 5 cycles mid-stream. Required:
  - `s_ready` drops.
  - `m_*` is held.
  - The output sequence is complete and in order.
- **Interpolation.** Configuration: `FADE_INTERP_EN`, INTERP_LOG2=2. Stimulus: coef (0,0), then coef (0x4000,0), then six samples (0x4000,0). Required `m_real` sequence: 0x0000, 0x0800, 0x1000, 0x1800, 0x2000, 0x2000.
- **Reset mid-stream.** Stimulus: assert `reset` with 3 samples in flight. Required:
  - `m_valid` = 0 and no stale outputs.
  - `s_ready` stays 0 until the next `coef_dv`.
